// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state encoding and port ids for the ram arbiter
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request ports and ram strobe bundle
interface mem_arbiter_if #(
  parameter int BITS = 32,
  parameter int ADDR = 9
);
  logic            if_req;
  logic [ADDR-1:0] if_addr;
  logic            if_ack;
  logic [BITS-1:0] if_rdata;

  logic            dm_req;
  logic            dm_we;
  logic [ADDR-1:0] dm_addr;
  logic [BITS-1:0] dm_wdata;
  logic            dm_ack;
  logic [BITS-1:0] dm_rdata;

  logic            ram_read;
  logic            ram_write;
  logic [ADDR-1:0] ram_address;
  logic [BITS-1:0] ram_dataIn;
  logic [BITS-1:0] ram_dataOut;

  // master: requesters plus the ram itself; slave: the arbiter
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_dataOut,
    input  if_ack, if_rdata, dm_ack, dm_rdata,
    input  ram_read, ram_write, ram_address, ram_dataIn
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, ram_dataOut,
    output if_ack, if_rdata, dm_ack, dm_rdata,
    output ram_read, ram_write, ram_address, ram_dataIn
  );
endinterface

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select; MEM_ARB_RR_EN enables round-robin on ties
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic  if_req,
  input  logic  dm_req,
  input  port_e last_grant,
  output logic  grant_valid,
  output port_e grant
);

  always_comb begin
    grant_valid = if_req | dm_req;
    grant       = PORT_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) begin
      grant = (last_grant == PORT_IF) ? PORT_DM : PORT_IF;
    end else if (dm_req) begin
      grant = PORT_DM;
    end
`else
    if (dm_req) begin
      grant = PORT_DM;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last;
  assign unused_last = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port ram between fetch and data ports, 4-cycle sequence
// MEM_ARB_RR_EN adds a last-grant flag so ties alternate instead of favouring the data port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BITS = 32,
  parameter int ADDR = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus,
  output logic            busy
);

  logic [1:0]      state_q, state_d;
  port_e           win_q, win_d;
  logic            we_q, we_d;
  logic            ram_read_q, ram_read_d;
  logic            ram_write_q, ram_write_d;
  logic [ADDR-1:0] ram_addr_q, ram_addr_d;
  logic [BITS-1:0] ram_wdata_q, ram_wdata_d;
  logic            if_ack_q, if_ack_d;
  logic            dm_ack_q, dm_ack_d;
  logic [BITS-1:0] if_rdata_q, if_rdata_d;
  logic [BITS-1:0] dm_rdata_q, dm_rdata_d;
  logic            busy_q, busy_d;
  port_e           last_q;
  logic            grant_valid;
  port_e           grant;

`ifdef MEM_ARB_RR_EN
  port_e last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= PORT_IF;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && grant_valid) last_d = grant;
  end
`else
  assign last_q = PORT_IF;
`endif

  mem_arb_pick u_pick (
    .if_req      (bus.if_req),
    .dm_req      (bus.dm_req),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          win_d = grant;
          if (grant == PORT_DM) begin
            we_d        = bus.dm_we;
            ram_addr_d  = bus.dm_addr;
            ram_read_d  = !bus.dm_we;
            ram_write_d = bus.dm_we;
            if (bus.dm_we) ram_wdata_d = bus.dm_wdata;
          end else begin
            we_d       = 1'b0;
            ram_addr_d = bus.if_addr;
            ram_read_d = 1'b1;
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // ram registered its read on the previous edge, so dataOut is valid now
        if (win_q == PORT_DM) begin
          dm_ack_d = 1'b1;
          if (!we_q) dm_rdata_d = bus.ram_dataOut;
        end else begin
          if_ack_d   = 1'b1;
          if_rdata_d = bus.ram_dataOut;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_q       <= PORT_IF;
      we_q        <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      we_q        <= we_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ram_read    = ram_read_q;
  assign bus.ram_write   = ram_write_q;
  assign bus.ram_address = ram_addr_q;
  assign bus.ram_dataIn  = ram_wdata_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.dm_ack      = dm_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural single-port ram
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        busy;
  int          cyc;
  int          n_vec;
  int          n_err;
  exp_t        if_q[$];
  exp_t        dm_q[$];
  logic [31:0] ram   [0:511];
  logic [31:0] model [0:511];
  logic [31:0] ram_dout;
  logic        pl_we;
  logic [8:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] dm_last;
  logic [31:0] exp_mem10;
  logic        mem10_req;
  logic        mem10_done;
  logic        final_chk;
  logic        done_chk;

  mem_arbiter_if #(.BITS(32), .ADDR(9)) bus ();

  mem_arbiter #(.BITS(32), .ADDR(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.ram_write) ram[bus.ram_address] <= bus.ram_dataIn;
    if (bus.ram_read) ram_dout <= ram[bus.ram_address];
  end

  assign bus.ram_dataOut = ram_dout;

  initial begin
    exp_t e;
    n_vec      = 0;
    n_err      = 0;
    mem10_done = 1'b0;
    done_chk   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_vec++;
        if (bus.ram_read || bus.ram_write || bus.if_ack || bus.dm_ack || busy ||
            bus.ram_address != 9'd0 || bus.ram_dataIn != 32'd0 ||
            bus.if_rdata != 32'd0 || bus.dm_rdata != 32'd0) begin
          n_err++;
          $display("FAIL reset_state: rd=%b wr=%b if_ack=%b dm_ack=%b busy=%b addr=%h din=%h ifr=%h dmr=%h, want all 0",
                   bus.ram_read, bus.ram_write, bus.if_ack, bus.dm_ack, busy,
                   bus.ram_address, bus.ram_dataIn, bus.if_rdata, bus.dm_rdata);
        end
      end else begin
        if (bus.ram_read || bus.ram_write || bus.if_ack || bus.dm_ack) begin
          n_vec++;
          if ((bus.ram_read && bus.ram_write) || (bus.if_ack && bus.dm_ack)) begin
            n_err++;
            $display("FAIL one_hot: rd=%b wr=%b if_ack=%b dm_ack=%b, want at most one of each pair",
                     bus.ram_read, bus.ram_write, bus.if_ack, bus.dm_ack);
          end
        end
        if (bus.if_ack) begin
          n_vec++;
          if (if_q.size() == 0) begin
            n_err++;
            $display("FAIL if_ack_spurious: got ack at cyc %0d, want no ack", cyc);
          end else begin
            e = if_q.pop_front();
            if (bus.if_rdata !== e.data || cyc != e.cyc || !busy) begin
              n_err++;
              $display("FAIL if_ack: got data=%h cyc=%0d busy=%b, want data=%h cyc=%0d busy=1",
                       bus.if_rdata, cyc, busy, e.data, e.cyc);
            end
          end
        end
        if (bus.dm_ack) begin
          n_vec++;
          if (dm_q.size() == 0) begin
            n_err++;
            $display("FAIL dm_ack_spurious: got ack at cyc %0d, want no ack", cyc);
          end else begin
            e = dm_q.pop_front();
            if (bus.dm_rdata !== e.data || cyc != e.cyc || !busy) begin
              n_err++;
              $display("FAIL dm_ack: got data=%h cyc=%0d busy=%b, want data=%h cyc=%0d busy=1",
                       bus.dm_rdata, cyc, busy, e.data, e.cyc);
            end
          end
        end
      end
      if (mem10_req && !mem10_done) begin
        n_vec++;
        if (ram[10] !== exp_mem10) begin
          n_err++;
          $display("FAIL reset_abort_write: got RAM[10]=%h, want %h", ram[10], exp_mem10);
        end
        mem10_done = 1'b1;
      end
      if (final_chk && !done_chk) begin
        n_vec++;
        if (if_q.size() != 0 || dm_q.size() != 0) begin
          n_err++;
          $display("FAIL pending_acks: got %0d if / %0d dm outstanding, want 0 / 0",
                   if_q.size(), dm_q.size());
        end
        done_chk = 1'b1;
      end
    end
  end

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    model[a] = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic issue_if(input logic [8:0] a, input logic [31:0] exp_d, input int exp_c);
    if_q.push_back('{data: exp_d, cyc: exp_c});
    bus.if_addr = a;
    bus.if_req  = 1'b1;
  endtask

  task automatic issue_dm(input logic we, input logic [8:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_d, input int exp_c);
    dm_q.push_back('{data: exp_d, cyc: exp_c});
    bus.dm_we    = we;
    bus.dm_addr  = a;
    bus.dm_wdata = wd;
    bus.dm_req   = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int k;
    k = 0;
    while ((bus.if_req || bus.dm_req) && k < maxc) begin
      @(posedge clk); #1;
      if (bus.if_ack) bus.if_req = 1'b0;
      if (bus.dm_ack) bus.dm_req = 1'b0;
      k++;
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    dm_last = 32'd0;
  endtask

  initial begin
    logic [8:0]  a;
    logic [31:0] d;
    rst_n        = 1'b0;
    cyc          = 0;
    pl_we        = 1'b0;
    pl_addr      = 9'd0;
    pl_data      = 32'd0;
    mem10_req    = 1'b0;
    final_chk    = 1'b0;
    dm_last      = 32'd0;
    exp_mem10    = 32'd0;
    bus.if_req   = 1'b0;
    bus.if_addr  = 9'd0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 9'd0;
    bus.dm_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 32; i++) preload(9'(i), 32'h5555_0000 + 32'(i));
    preload(9'd4, 32'h1234);
    preload(9'd20, 32'hABCD);

    // 1: single fetch, ack three cycles after the request is seen
    @(posedge clk); #1;
    issue_if(9'd4, 32'h1234, cyc + 3);
    drain(10);

    // 2: store then load of the same word; the store keeps dm_rdata
    @(posedge clk); #1;
    issue_dm(1'b1, 9'd85, 32'hF7F7, dm_last, cyc + 3);
    drain(10);
    @(posedge clk); #1;
    issue_dm(1'b0, 9'd85, 32'h0, 32'hF7F7, cyc + 3);
    drain(10);
    model[85] = 32'hF7F7;

    // 3: same-cycle tie from a fresh reset: data first, then fetch
    pulse_reset();
    @(posedge clk); #1;
    issue_if(9'd4, 32'h1234, cyc + 7);
    issue_dm(1'b0, 9'd20, 32'h0, 32'hABCD, cyc + 3);
    drain(20);
    dm_last = 32'hABCD;

    // 4: both held continuously for four grants
    @(posedge clk); #1;
`ifdef MEM_ARB_RR_EN
    issue_dm(1'b0, 9'd20, 32'h0, 32'hABCD, cyc + 3);
    if_q.push_back('{data: 32'h1234, cyc: cyc + 7});
    dm_q.push_back('{data: 32'hABCD, cyc: cyc + 11});
    if_q.push_back('{data: 32'h1234, cyc: cyc + 15});
    bus.if_addr = 9'd4;
    bus.if_req  = 1'b1;
`else
    issue_dm(1'b0, 9'd20, 32'h0, 32'hABCD, cyc + 3);
    for (int k = 1; k < 4; k++) dm_q.push_back('{data: 32'hABCD, cyc: cyc + 3 + 4 * k});
    bus.if_addr = 9'd4;
    bus.if_req  = 1'b1;
`endif
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;

    // 6: sequential random mix against the shadow model
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      a = 9'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        issue_if(a, model[a], cyc + 3);
      end else if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        issue_dm(1'b1, a, d, dm_last, cyc + 3);
        model[a] = d;
      end else begin
        issue_dm(1'b0, a, 32'h0, model[a], cyc + 3);
        dm_last = model[a];
      end
      drain(10);
    end

    // 5: reset lands while the store strobe is up; the write must not commit
    @(posedge clk); #1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 9'd10;
    bus.dm_wdata = 32'hAA;
    bus.dm_req   = 1'b1;
    @(posedge clk); #1;
    rst_n      = 1'b0;
    bus.dm_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n  = 1'b1;
    exp_mem10 = model[10];
    mem10_req = 1'b1;
    repeat (3) @(posedge clk);

    final_chk = 1'b1;
    for (int k = 0; k < 5 && !done_chk; k++) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
